// File: rtl/reg_share_arb_if.sv
// reg_share_arb_if: requester and bank-side signals of the shared register
// bank arbiter.
//   master : requester/bank environment (drives req*, wdata*, clr, bank_q)
//   slave  : the arbiter (drives bank_*, gnt*, done, err, busy)
interface reg_share_arb_if #(parameter int WIDTH = 8);
  logic             req0, req1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             clr;
  logic [WIDTH-1:0] bank_q;
  logic             bank_clk;
  logic [WIDTH-1:0] bank_d;
  logic             bank_Rb, bank_Sb;
  logic             gnt0, gnt1;
  logic             done, err, busy;

  modport master (
    output req0, req1, wdata0, wdata1, clr, bank_q,
    input  bank_clk, bank_d, bank_Rb, bank_Sb, gnt0, gnt1, done, err, busy
  );

  modport slave (
    input  req0, req1, wdata0, wdata1, clr, bank_q,
    output bank_clk, bank_d, bank_Rb, bank_Sb, gnt0, gnt1, done, err, busy
  );
endinterface

// File: rtl/reg_share_arb.sv
// reg_share_arb: two-requester arbiter for a shared latch-cell register bank.
// A winning requester gets its data onto bank_d, the bank enable is pulsed for
// HOLD cycles, the readback is compared and done/err report the outcome.
// clr from IDLE runs a one-cycle bank clear instead.
// Ports:
//   clk  - rising-edge clock
//   Rb   - asynchronous active-low reset (also clears the bank while low)
//   bus  - reg_share_arb_if.slave: requests/data/clr/readback in,
//          bank controls, grants, done/err/busy out
module reg_share_arb #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input logic            clk,
  input logic            Rb,
  reg_share_arb_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CHECK, DONE, CLEAR} state_t;

  localparam logic [3:0] HLAST = 4'(HOLD - 1);

  state_t           state, nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             last, last_nxt;
  logic             win;
  logic [WIDTH-1:0] d_q, d_nxt;
  logic             g0_q, g1_q, g0_nxt, g1_nxt;
  logic             err_q, err_nxt;
  logic             done_q, busy_q, bclk_q, rb_q;

  // Tie goes to whoever was not served last; otherwise the sole requester.
  assign win = (bus.req0 & bus.req1) ? ~last : bus.req1;

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    last_nxt = last;
    d_nxt    = d_q;
    g0_nxt   = g0_q;
    g1_nxt   = g1_q;
    err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          nxt = CLEAR;
        end else if (bus.req0 | bus.req1) begin
          nxt      = SETUP;
          last_nxt = win;
          d_nxt    = win ? bus.wdata1 : bus.wdata0;
          g0_nxt   = ~win;
          g1_nxt   = win;
        end
      end
      SETUP: begin
        nxt     = STROBE;
        cnt_nxt = 4'd0;
      end
      STROBE: begin
        if (cnt == HLAST) nxt = CHECK;
        else              cnt_nxt = cnt + 4'd1;
      end
      CHECK: begin
        nxt     = DONE;
        err_nxt = (bus.bank_q != d_q);
      end
      DONE: begin
        nxt    = IDLE;
        g0_nxt = 1'b0;
        g1_nxt = 1'b0;
      end
      CLEAR:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge Rb) begin
    if (!Rb) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last   <= 1'b1;
      d_q    <= '0;
      g0_q   <= 1'b0;
      g1_q   <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      bclk_q <= 1'b0;
      rb_q   <= 1'b1;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      d_q    <= d_nxt;
      g0_q   <= g0_nxt;
      g1_q   <= g1_nxt;
      err_q  <= err_nxt;
      done_q <= (nxt == DONE);
      busy_q <= (nxt != IDLE);
      bclk_q <= (nxt == STROBE);
      rb_q   <= (nxt != CLEAR);
    end
  end

  // Bank clear follows Rb directly so the cells are held cleared during reset
  // and released as soon as Rb rises.
  assign bus.bank_Rb  = Rb & rb_q;
  assign bus.bank_Sb  = 1'b1;
  assign bus.bank_clk = bclk_q;
  assign bus.bank_d   = d_q;
  assign bus.gnt0     = g0_q;
  assign bus.gnt1     = g1_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
endmodule
